// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the interleaved DAC sequencer.
// Slot encoding matches the DAC latch rule: wrt low latches A when sel=0, B when sel=1.
package dac_ctrl_pkg;

  localparam int DW_DEF      = 14;
  localparam int RST_CYC_DEF = 16;

  typedef enum logic [1:0] {
    RST_HOLD,
    IDLE,
    RUN_A,
    RUN_B
  } state_t;

  localparam logic SEL_A      = 1'b0;
  localparam logic SEL_B      = 1'b1;
  localparam logic WRT_ACTIVE = 1'b0;
  localparam logic WRT_IDLE   = 1'b1;

  function automatic logic is_run(input state_t s);
    return (s == RUN_A) || (s == RUN_B);
  endfunction

endpackage

// File: rtl/dac_interleave_ctrl_if.sv
// Sample-stream, control and DAC-pin bundle for dac_interleave_ctrl.
// Optional underrun counter signals appear when DAC_URUN_CNT_EN is defined.
interface dac_interleave_ctrl_if #(parameter int DW = dac_ctrl_pkg::DW_DEF);

  logic          enable_i;
  logic          urun_hold_i;
  logic [DW-1:0] cha_dat_i;
  logic          cha_vld_i;
  logic          cha_rdy_o;
  logic [DW-1:0] chb_dat_i;
  logic          chb_vld_i;
  logic          chb_rdy_o;
  logic [DW-1:0] dac_dat_o;
  logic          dac_sel_o;
  logic          dac_wrt_o;
  logic          dac_rst_o;
  logic          busy_o;
`ifdef DAC_URUN_CNT_EN
  logic          urun_clr_i;
  logic [15:0]   urun_cnt_a_o;
  logic [15:0]   urun_cnt_b_o;
`endif

  modport slave (
    input  enable_i, urun_hold_i, cha_dat_i, cha_vld_i, chb_dat_i, chb_vld_i,
`ifdef DAC_URUN_CNT_EN
    input  urun_clr_i,
    output urun_cnt_a_o, urun_cnt_b_o,
`endif
    output cha_rdy_o, chb_rdy_o, dac_dat_o, dac_sel_o, dac_wrt_o, dac_rst_o, busy_o
  );

  modport master (
    output enable_i, urun_hold_i, cha_dat_i, cha_vld_i, chb_dat_i, chb_vld_i,
`ifdef DAC_URUN_CNT_EN
    output urun_clr_i,
    input  urun_cnt_a_o, urun_cnt_b_o,
`endif
    input  cha_rdy_o, chb_rdy_o, dac_dat_o, dac_sel_o, dac_wrt_o, dac_rst_o, busy_o
  );

endinterface

// File: rtl/dac_slot_buf.sv
// One-entry per-channel holding register, drained only in its own DAC slot.
// Latency: accept-to-drain >= 1 cycle; ready while empty or being drained; holds off for the cycle after reset.
module dac_slot_buf
  import dac_ctrl_pkg::*;
#(
  parameter int            DW       = DW_DEF,
  parameter logic [DW-1:0] IDLE_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_dat,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic          drain,
  input  logic          urun_hold,
  output logic [DW-1:0] slot_dat,
  output logic          urun
);

  logic          live;
  logic          full;
  logic          accept;
  logic [DW-1:0] buf_dat;
  logic [DW-1:0] last_dat;

  // live keeps ready low for the first cycle out of reset
  assign in_rdy = live && (!full || drain);
  assign accept = in_vld && in_rdy;
  assign urun   = drain && !full;

  always_comb begin
    slot_dat = buf_dat;
    if (!full) slot_dat = urun_hold ? last_dat : IDLE_VAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live     <= 1'b0;
      full     <= 1'b0;
      buf_dat  <= IDLE_VAL;
      last_dat <= IDLE_VAL;
    end else begin
      live <= 1'b1;
      if (accept) begin
        full    <= 1'b1;
        buf_dat <= in_dat;
      end else if (drain) begin
        full <= 1'b0;
      end
      if (drain && full) last_dat <= buf_dat;
    end
  end

endmodule

// File: rtl/dac_interleave_ctrl.sv
// Interleaves channel A/B sample streams onto the shared DAC bus and sequences DAC reset.
// Latency: slot state to pins 1 cycle, accept to pins >= 2; backpressure via 1-deep per-channel buffers.
// Optional DAC_URUN_CNT_EN adds saturating per-channel underrun counters with clear.
module dac_interleave_ctrl
  import dac_ctrl_pkg::*;
#(
  parameter int            DW       = DW_DEF,
  parameter int            RST_CYC  = RST_CYC_DEF,
  parameter logic [DW-1:0] IDLE_VAL = '0
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rst_i,
  dac_interleave_ctrl_if.slave  bus
);

  localparam int            CW       = $clog2(RST_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYC - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          drain_a;
  logic          drain_b;
  logic [DW-1:0] a_slot;
  logic [DW-1:0] b_slot;
  logic          urun_a;
  logic          urun_b;

  logic [DW-1:0] dat_q;
  logic          sel_q;
  logic          wrt_q;
  logic          rst_q;
  logic          busy_q;

  dac_slot_buf #(.DW(DW), .IDLE_VAL(IDLE_VAL)) u_buf_a (
    .clk       (dac_clk_i),
    .rst       (dac_rst_i),
    .in_dat    (bus.cha_dat_i),
    .in_vld    (bus.cha_vld_i),
    .in_rdy    (bus.cha_rdy_o),
    .drain     (drain_a),
    .urun_hold (bus.urun_hold_i),
    .slot_dat  (a_slot),
    .urun      (urun_a)
  );

  dac_slot_buf #(.DW(DW), .IDLE_VAL(IDLE_VAL)) u_buf_b (
    .clk       (dac_clk_i),
    .rst       (dac_rst_i),
    .in_dat    (bus.chb_dat_i),
    .in_vld    (bus.chb_vld_i),
    .in_rdy    (bus.chb_rdy_o),
    .drain     (drain_b),
    .urun_hold (bus.urun_hold_i),
    .slot_dat  (b_slot),
    .urun      (urun_b)
  );

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state <= RST_HOLD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Pairs are never split: RUN_A always proceeds to RUN_B, enable is checked after B
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    drain_a   = 1'b0;
    drain_b   = 1'b0;
    case (state)
      RST_HOLD: begin
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      IDLE: begin
        if (bus.enable_i) state_nxt = RUN_A;
      end
      RUN_A: begin
        drain_a   = 1'b1;
        state_nxt = RUN_B;
      end
      RUN_B: begin
        drain_b   = 1'b1;
        state_nxt = bus.enable_i ? RUN_A : IDLE;
      end
      default: state_nxt = RST_HOLD;
    endcase
  end

  // rst/busy follow the state register; the slot bus lags the slot state by one cycle
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      dat_q  <= IDLE_VAL;
      sel_q  <= SEL_A;
      wrt_q  <= WRT_IDLE;
      rst_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      dat_q <= IDLE_VAL;
      sel_q <= SEL_A;
      wrt_q <= WRT_IDLE;
      if (state == RUN_A) begin
        dat_q <= a_slot;
        sel_q <= SEL_A;
        wrt_q <= WRT_ACTIVE;
      end else if (state == RUN_B) begin
        dat_q <= b_slot;
        sel_q <= SEL_B;
        wrt_q <= WRT_ACTIVE;
      end
      rst_q  <= (state_nxt == RST_HOLD);
      busy_q <= is_run(state_nxt);
    end
  end

  assign bus.dac_dat_o = dat_q;
  assign bus.dac_sel_o = sel_q;
  assign bus.dac_wrt_o = wrt_q;
  assign bus.dac_rst_o = rst_q;
  assign bus.busy_o    = busy_q;

`ifdef DAC_URUN_CNT_EN
  logic [15:0] ucnt_a;
  logic [15:0] ucnt_b;

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i || bus.urun_clr_i) begin
      ucnt_a <= '0;
      ucnt_b <= '0;
    end else begin
      if (urun_a && (ucnt_a != 16'hFFFF)) ucnt_a <= ucnt_a + 16'd1;
      if (urun_b && (ucnt_b != 16'hFFFF)) ucnt_b <= ucnt_b + 16'd1;
    end
  end

  assign bus.urun_cnt_a_o = ucnt_a;
  assign bus.urun_cnt_b_o = ucnt_b;
`else
  logic unused_urun;
  assign unused_urun = urun_a ^ urun_b;
`endif

endmodule

// File: tb/tb_dac_interleave_ctrl.sv
// Directed bench for dac_interleave_ctrl: reset sequence, streaming, underrun, enable drop, mid-run reset.
// Underrun counter scenario is built when DAC_URUN_CNT_EN is defined.
`timescale 1ns/1ps
module tb_dac_interleave_ctrl;

  localparam int DW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_interleave_ctrl_if #(.DW(DW)) bus ();

  dac_interleave_ctrl #(.DW(DW), .RST_CYC(16), .IDLE_VAL(14'd0)) dut (
    .dac_clk_i (clk),
    .dac_rst_i (rst),
    .bus       (bus)
  );

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] a_next, b_next, a_last, b_last, exp_a, exp_b;

  // One clock; records handshakes seen just before the edge and advances the sources.
  task automatic step();
    logic acc_a, acc_b;
    @(negedge clk);
    acc_a = bus.cha_vld_i && bus.cha_rdy_o;
    acc_b = bus.chb_vld_i && bus.chb_rdy_o;
    @(posedge clk);
    #1;
    if (acc_a) begin
      a_last        = bus.cha_dat_i;
      a_next        = a_next + 14'd1;
      bus.cha_dat_i = a_next;
    end
    if (acc_b) begin
      b_last        = bus.chb_dat_i;
      b_next        = b_next - 14'd1;
      bus.chb_dat_i = b_next;
    end
  endtask

  // n full A/B pairs from an A-slot boundary; B is either the running sequence or a fixed value
  task automatic run_pairs(input int n, input bit b_fixed, input logic [DW-1:0] b_val);
    logic [DW-1:0] eb;
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if (bus.dac_wrt_o !== 1'b0 || bus.dac_sel_o !== 1'b0 || bus.dac_dat_o !== exp_a)
        $display("FAIL a_slot[%0d]: wrt=%b sel=%b dat=%h, want wrt=0 sel=0 dat=%h",
                 i, bus.dac_wrt_o, bus.dac_sel_o, bus.dac_dat_o, exp_a);
      else passes++;
      exp_a = exp_a + 14'd1;
      step();
      eb = b_fixed ? b_val : exp_b;
      checks++;
      if (bus.dac_wrt_o !== 1'b0 || bus.dac_sel_o !== 1'b1 || bus.dac_dat_o !== eb)
        $display("FAIL b_slot[%0d]: wrt=%b sel=%b dat=%h, want wrt=0 sel=1 dat=%h",
                 i, bus.dac_wrt_o, bus.dac_sel_o, bus.dac_dat_o, eb);
      else passes++;
      if (!b_fixed) exp_b = exp_b - 14'd1;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.dac_rst_o !== 1'b1 || bus.dac_wrt_o !== 1'b1 || bus.busy_o !== 1'b0 ||
        bus.cha_rdy_o !== 1'b0 || bus.chb_rdy_o !== 1'b0 || bus.dac_sel_o !== 1'b0 ||
        bus.dac_dat_o !== 14'd0)
      $display("FAIL reset_vals: rst=%b wrt=%b busy=%b rdy=%b%b sel=%b dat=%h, want 1 1 0 00 0 0000",
               bus.dac_rst_o, bus.dac_wrt_o, bus.busy_o, bus.cha_rdy_o, bus.chb_rdy_o,
               bus.dac_sel_o, bus.dac_dat_o);
    else passes++;
    rst = 1'b0;
    n = 1;
    for (int i = 0; i < 40 && bus.dac_rst_o === 1'b1; i++) begin
      step();
      checks++;
      if (bus.dac_wrt_o !== 1'b1)
        $display("FAIL rst_hold_wrt: wrt=%b want 1", bus.dac_wrt_o);
      else passes++;
      if (bus.dac_rst_o === 1'b1) n++;
    end
    checks++;
    if (n != 16 || bus.dac_rst_o !== 1'b0)
      $display("FAIL rst_len: rst_o high %0d cycles (now %b), want 16 then 0", n, bus.dac_rst_o);
    else passes++;
    checks++;
    if (bus.dac_dat_o !== 14'd0 || bus.busy_o !== 1'b0)
      $display("FAIL idle_bus: dat=%h busy=%b, want 0000 0", bus.dac_dat_o, bus.busy_o);
    else passes++;
  endtask

  task automatic test_stream();
    a_next = 14'd100;
    b_next = 14'h3FFB;  // -5
    exp_a  = 14'd100;
    exp_b  = 14'h3FFB;
    bus.cha_dat_i   = a_next;
    bus.chb_dat_i   = b_next;
    bus.cha_vld_i   = 1'b1;
    bus.chb_vld_i   = 1'b1;
    bus.urun_hold_i = 1'b1;
    step();
    step();
    checks++;
    if (bus.cha_rdy_o !== 1'b0 || bus.chb_rdy_o !== 1'b0 || bus.dac_wrt_o !== 1'b1)
      $display("FAIL idle_backpressure: rdy=%b%b wrt=%b, want 00 1",
               bus.cha_rdy_o, bus.chb_rdy_o, bus.dac_wrt_o);
    else passes++;
    bus.enable_i = 1'b1;
    step();
    checks++;
    if (bus.dac_wrt_o !== 1'b1 || bus.busy_o !== 1'b1)
      $display("FAIL start_latency: wrt=%b busy=%b, want 1 1", bus.dac_wrt_o, bus.busy_o);
    else passes++;
    run_pairs(6, 1'b0, '0);
  endtask

  task automatic test_underrun();
    bus.chb_vld_i   = 1'b0;
    bus.urun_hold_i = 1'b1;
    run_pairs(4, 1'b1, b_last);
    bus.urun_hold_i = 1'b0;
    run_pairs(3, 1'b1, 14'd0);
    bus.chb_vld_i = 1'b1;
    exp_b = b_next;
    run_pairs(3, 1'b0, '0);
  endtask

  task automatic test_enable_drop();
    bus.enable_i = 1'b0;
    run_pairs(1, 1'b0, '0);
    step();
    checks++;
    if (bus.dac_wrt_o !== 1'b1 || bus.dac_dat_o !== 14'd0 || bus.busy_o !== 1'b0)
      $display("FAIL drop_idle: wrt=%b dat=%h busy=%b, want 1 0000 0",
               bus.dac_wrt_o, bus.dac_dat_o, bus.busy_o);
    else passes++;
    step();
    checks++;
    if (bus.dac_wrt_o !== 1'b1 || bus.cha_rdy_o !== 1'b0)
      $display("FAIL drop_retain: wrt=%b rdy_a=%b, want 1 0", bus.dac_wrt_o, bus.cha_rdy_o);
    else passes++;
    bus.enable_i = 1'b1;
    step();
    checks++;
    if (bus.dac_wrt_o !== 1'b1 || bus.busy_o !== 1'b1)
      $display("FAIL restart: wrt=%b busy=%b, want 1 1", bus.dac_wrt_o, bus.busy_o);
    else passes++;
    run_pairs(2, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    int i;
    run_pairs(1, 1'b0, '0);
    step();  // pins show A, FSM now in RUN_B
    rst = 1'b1;
    bus.cha_vld_i = 1'b0;
    bus.chb_vld_i = 1'b0;
    step();
    checks++;
    if (bus.dac_wrt_o !== 1'b1 || bus.cha_rdy_o !== 1'b0 || bus.chb_rdy_o !== 1'b0 ||
        bus.dac_rst_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.dac_dat_o !== 14'd0)
      $display("FAIL mid_reset: wrt=%b rdy=%b%b rst=%b busy=%b dat=%h, want 1 00 1 0 0000",
               bus.dac_wrt_o, bus.cha_rdy_o, bus.chb_rdy_o, bus.dac_rst_o, bus.busy_o,
               bus.dac_dat_o);
    else passes++;
    rst = 1'b0;
    bus.urun_hold_i = 1'b1;
    i = 0;
    while (i < 60 && bus.dac_wrt_o !== 1'b0) begin
      step();
      i++;
    end
    checks++;
    if (bus.dac_wrt_o !== 1'b0 || bus.dac_sel_o !== 1'b0 || bus.dac_dat_o !== 14'd0)
      $display("FAIL flush_a: wrt=%b sel=%b dat=%h, want 0 0 0000",
               bus.dac_wrt_o, bus.dac_sel_o, bus.dac_dat_o);
    else passes++;
    step();
    checks++;
    if (bus.dac_wrt_o !== 1'b0 || bus.dac_sel_o !== 1'b1 || bus.dac_dat_o !== 14'd0)
      $display("FAIL flush_b: wrt=%b sel=%b dat=%h, want 0 1 0000",
               bus.dac_wrt_o, bus.dac_sel_o, bus.dac_dat_o);
    else passes++;
  endtask

`ifdef DAC_URUN_CNT_EN
  task automatic test_urun_cnt();
    int i;
    rst = 1'b1;
    bus.cha_vld_i = 1'b0;
    bus.chb_vld_i = 1'b0;
    bus.enable_i  = 1'b1;
    step();
    rst = 1'b0;
    i = 0;
    while (i < 60 && bus.dac_wrt_o !== 1'b0) begin
      step();
      i++;
    end
    repeat (8) step();  // fifth A underrun slot on the pins
    checks++;
    if (bus.urun_cnt_a_o !== 16'd5 || bus.urun_cnt_b_o !== 16'd4)
      $display("FAIL urun_cnt: a=%0d b=%0d, want 5 4", bus.urun_cnt_a_o, bus.urun_cnt_b_o);
    else passes++;
    bus.urun_clr_i = 1'b1;
    step();
    bus.urun_clr_i = 1'b0;
    checks++;
    if (bus.urun_cnt_a_o !== 16'd0 || bus.urun_cnt_b_o !== 16'd0)
      $display("FAIL urun_clr: a=%0d b=%0d, want 0 0", bus.urun_cnt_a_o, bus.urun_cnt_b_o);
    else passes++;
    step();
    checks++;
    if (bus.urun_cnt_a_o !== 16'd1 || bus.urun_cnt_b_o !== 16'd0)
      $display("FAIL urun_recount: a=%0d b=%0d, want 1 0", bus.urun_cnt_a_o, bus.urun_cnt_b_o);
    else passes++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable_i    = 1'b0;
    bus.urun_hold_i = 1'b1;
    bus.cha_dat_i   = '0;
    bus.cha_vld_i   = 1'b0;
    bus.chb_dat_i   = '0;
    bus.chb_vld_i   = 1'b0;
`ifdef DAC_URUN_CNT_EN
    bus.urun_clr_i  = 1'b0;
`endif
    a_next = '0;
    b_next = '0;
    a_last = '0;
    b_last = '0;
    exp_a  = '0;
    exp_b  = '0;
    test_reset();
    test_stream();
    test_underrun();
    test_enable_drop();
    test_reset_mid();
`ifdef DAC_URUN_CNT_EN
    test_urun_cnt();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
